// File: rtl/mul_requester_pkg.sv
// Shared types and helpers for the Booth multiplier command-side requester.
package mul_requester_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        RUN   = ST_RUN,
        RESP  = ST_RESP
    } state_t;

    // Watchdog must be able to represent TIMEOUT itself.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder slice; chain through i_cin/o_cout for wider sums.
module cla8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is the flat sum-of-products over all lower generate terms.
    always_comb begin
        logic v_term;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < 8; i++) begin
            v_term     = 1'b1;
            w_c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                w_c[i + 1] = w_c[i + 1] | (v_term & w_g[j]);
                v_term     = v_term & w_p[j];
            end
            w_c[i + 1] = w_c[i + 1] | (v_term & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[7:0];
    assign o_cout = w_c[8];

endmodule

// File: rtl/mul_req_watchdog.sv
// Saturating RUN-phase watchdog: loadable up-counter with clear, enable and
// a terminal-count flag at TIMEOUT-1.
module mul_req_watchdog
    import mul_requester_pkg::*;
#(
    parameter int TIMEOUT = 100,
    parameter int W       = wd_width(TIMEOUT)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    localparam int N = (W + 7) / 8;
    localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

    logic [W-1:0]   r_count;
    logic [N*8-1:0] w_a;
    logic [N*8-1:0] w_sum;
    logic [N:0]     w_carry;
    logic           w_ovf;
    logic           w_tc;

    always_comb begin
        w_a          = '0;
        w_a[W-1:0]   = r_count;
    end

    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_cla
        cla8 u_cla (
            .i_a    (w_a[g*8 +: 8]),
            .i_b    (8'd0),
            .i_cin  (w_carry[g]),
            .o_sum  (w_sum[g*8 +: 8]),
            .o_cout (w_carry[g + 1])
        );
    end

    // Any carry out of the live W bits means the increment would wrap.
    always_comb begin
        w_ovf = w_carry[N];
        for (int i = W; i < N * 8; i++) begin
            w_ovf = w_ovf | w_sum[i];
        end
    end

    assign w_tc = (r_count == TC_VAL);
    assign o_tc = w_tc;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_tc && !w_ovf) begin
            r_count <= w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/mul_requester.sv
// Command-side controller: accepts an operand pair, sequences the Booth core
// through clear/start, waits for done (or watchdog timeout) and returns the product.
module mul_requester
    import mul_requester_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_W-1:0]     req_a,
    input  logic [DATA_W-1:0]     req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_result,
    output logic                  rsp_error,
    output logic                  op_start,
    output logic                  op_clear,
    output logic [DATA_W-1:0]     multiplicand,
    output logic [DATA_W-1:0]     multiplier,
    input  logic                  op_done,
    input  logic [2*DATA_W-1:0]   result,
    output logic                  busy,
    output logic [1:0]            o_dbg_state
);

    localparam int WD_W = wd_width(TIMEOUT);

    // Both ports transfer on a rising edge where valid and ready are high;
    // valid never drops before ready and the payload is held until then.

    state_t r_state;
    state_t w_next;
    logic   w_wd_tc;

    mul_req_watchdog #(
        .TIMEOUT (TIMEOUT),
        .W       (WD_W)
    ) u_watchdog (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (r_state == CLEAR),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == RUN),
        .o_tc       (w_wd_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = CLEAR;
            CLEAR:   w_next = RUN;
            RUN:     if (op_done || w_wd_tc) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign req_ready   = (r_state == IDLE);
    assign o_dbg_state = r_state;

    // Control outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            op_clear     <= 1'b0;
            op_start     <= 1'b0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
            rsp_result   <= '0;
            rsp_error    <= 1'b0;
            multiplicand <= '0;
            multiplier   <= '0;
        end else begin
            r_state   <= w_next;
            op_clear  <= (w_next == CLEAR);
            op_start  <= (w_next == RUN);
            rsp_valid <= (w_next == RESP);
            busy      <= (w_next != IDLE);
            if (r_state == IDLE && req_valid) begin
                multiplicand <= req_a;
                multiplier   <= req_b;
            end
            if (r_state == RUN) begin
                if (op_done) begin
                    rsp_result <= result;
                    rsp_error  <= 1'b0;
                end else if (w_wd_tc) begin
                    rsp_result <= '0;
                    rsp_error  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_requester.sv
// Directed bench for mul_requester with a behavioural Booth-core model.
module tb_mul_requester;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic         rsp_error;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic         op_done;
  logic [127:0] result;
  logic         busy;
  logic [1:0]   o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // model: op_done rises model_lat cycles after op_start rises; 0 = never
  int   model_lat = 65;
  int   m_cnt = 0;
  logic m_done = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!op_start) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_cnt  <= m_cnt + 1;
      m_done <= (model_lat != 0) && (m_cnt + 1 >= model_lat);
    end
  end

  assign op_done = m_done;
  assign result  = $signed({{64{multiplicand[63]}}, multiplicand}) *
                   $signed({{64{multiplier[63]}}, multiplier});

  mul_requester dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_error    (rsp_error),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result),
    .busy         (busy),
    .o_dbg_state  (o_dbg_state)
  );

  // cycle numbering: the negedge after accepting edge T is cycle T+1
  task automatic send_req(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: got ready=%b valid=%b busy=%b want 1 0 0", req_ready, rsp_valid, busy);
    end
    n_tests++;
    if (op_start !== 1'b0 || op_clear !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got start=%b clear=%b state=%0d want 0 0 0", op_start, op_clear, o_dbg_state);
    end
    n_tests++;
    if (rsp_result !== 128'd0 || rsp_error !== 1'b0 || multiplicand !== 64'd0 || multiplier !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got res=%h err=%b a=%h b=%h want zeros", rsp_result, rsp_error, multiplicand, multiplier);
    end
  endtask

  task automatic test_basic();
    int cyc;
    model_lat = 65;
    send_req(64'd3, 64'd5);
    n_tests++;
    if (op_clear !== 1'b1 || op_start !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_clear_t1: got clear=%b start=%b want 1 0", op_clear, op_start);
    end
    n_tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got ready=%b busy=%b want 0 1", req_ready, busy);
    end
    @(negedge clk);
    n_tests++;
    if (op_clear !== 1'b0 || op_start !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start_t2: got clear=%b start=%b want 0 1", op_clear, op_start);
    end
    n_tests++;
    if (multiplicand !== 64'd3 || multiplier !== 64'd5) begin
      n_fail++;
      $display("FAIL basic_operands: got a=%0d b=%0d want 3 5", multiplicand, multiplier);
    end
    wait_rsp(2, cyc);
    n_tests++;
    if (cyc !== 68) begin
      n_fail++;
      $display("FAIL basic_latency: got cycle %0d want 68", cyc);
    end
    n_tests++;
    if (rsp_result !== 128'd15 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %h err=%b want 15 err=0", rsp_result, rsp_error);
    end
    finish_rsp();
  endtask

  task automatic test_signed();
    int cyc;
    logic [127:0] exp_res;
    exp_res   = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2;
    model_lat = 65;
    send_req(64'hFFFF_FFFF_FFFF_FFFE, 64'd7);
    wait_rsp(1, cyc);
    n_tests++;
    if (rsp_result !== exp_res || rsp_error !== 1'b0 || cyc !== 68) begin
      n_fail++;
      $display("FAIL signed_result: got %h err=%b cyc=%0d want %h err=0 cyc=68", rsp_result, rsp_error, cyc, exp_res);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int cyc;
    model_lat = 65;
    send_req(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_rsp(1, cyc);
    n_tests++;
    if (cyc !== 68 || rsp_result !== 128'd12) begin
      n_fail++;
      $display("FAIL stall_first: got cyc=%0d res=%h want 68 12", cyc, rsp_result);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 128'd12 || rsp_error !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b res=%h err=%b want 1 12 0", i, rsp_valid, rsp_result, rsp_error);
      end
      n_tests++;
      if (req_ready !== 1'b0 || op_start !== 1'b0 || op_clear !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ctl[%0d]: got ready=%b start=%b clear=%b want 0 0 0", i, req_ready, op_start, op_clear);
      end
    end
    // offer a request during the handshake cycle: it must not be taken
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 64'd100;
    req_b     = 64'd100;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    n_tests++;
    if (req_ready !== 1'b1 || o_dbg_state !== 2'd0 || rsp_valid !== 1'b0 || op_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got ready=%b state=%0d valid=%b clear=%b want 1 0 0 0", req_ready, o_dbg_state, rsp_valid, op_clear);
    end
    n_tests++;
    if (multiplicand !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++;
      $display("FAIL stall_no_accept: got a=%h want fffffffffffffffd", multiplicand);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    model_lat = 0;
    send_req(64'd11, 64'd13);
    wait_rsp(1, cyc);
    n_tests++;
    if (cyc !== 102) begin
      n_fail++;
      $display("FAIL timeout_latency: got cycle %0d want 102", cyc);
    end
    n_tests++;
    if (rsp_error !== 1'b1 || rsp_result !== 128'd0) begin
      n_fail++;
      $display("FAIL timeout_resp: got err=%b res=%h want 1 0", rsp_error, rsp_result);
    end
    finish_rsp();
  endtask

  task automatic test_done_at_tc();
    int cyc;
    model_lat = 99;
    send_req(64'd6, 64'd7);
    wait_rsp(1, cyc);
    n_tests++;
    if (cyc !== 102 || rsp_error !== 1'b0 || rsp_result !== 128'd42) begin
      n_fail++;
      $display("FAIL done_at_tc: got cyc=%0d err=%b res=%h want 102 0 42", cyc, rsp_error, rsp_result);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    model_lat = 65;
    send_req(64'd3, 64'd5);
    repeat (31) @(negedge clk);
    n_tests++;
    if (op_start !== 1'b1 || o_dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL midrun_in_run: got start=%b state=%0d want 1 2", op_start, o_dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (o_dbg_state !== 2'd0 || op_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: got state=%0d start=%b valid=%b busy=%b ready=%b want 0 0 0 0 1",
               o_dbg_state, op_start, rsp_valid, busy, req_ready);
    end
    n_tests++;
    if (rsp_result !== 128'd0 || multiplicand !== 64'd0) begin
      n_fail++;
      $display("FAIL midrun_regs: got res=%h a=%h want 0 0", rsp_result, multiplicand);
    end
    send_req(64'd9, 64'd9);
    wait_rsp(1, cyc);
    n_tests++;
    if (cyc !== 68 || rsp_result !== 128'd81 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_after: got cyc=%0d res=%h err=%b want 68 81 0", cyc, rsp_result, rsp_error);
    end
    finish_rsp();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_timeout();
    test_done_at_tc();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got stuck want finish");
    $fatal(1, "global timeout");
  end

endmodule
